mdu_iter: RTL and testbench

Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU. The ALU returns its result in the same cycle. This block takes a one-cycle start pulse with two 32-bit operands, raises `busy` for a fixed number of cycles, and then commits the 64-bit result into architectural HI/LO. The hazard unit stalls the pipeline on `busy` or `start`. The block also serves MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO reads.

---
 rtl/mdu_if.sv | 13 +
 rtl/mdu_iter.sv | 69 ++++++
 tb/tb_mdu_iter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mdu_if.sv
// mdu_if: EX-stage handshake between the pipeline and the multiply/divide unit.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, op, a, b, flush, input busy, hi, lo);
    modport slave (input start, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle mult/div unit owning HI/LO; result is computed at start
// and held pending until the fixed busy window expires.
module mdu_iter #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input logic   clk,
    input logic   rst_n,
    mdu_if.slave  bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic [63:0] pend;
    logic        pend_ok;
    logic [63:0] res;
    logic [31:0] abs_a, abs_b, dvs, q, r;
    logic        is_div, is_sdiv, dz;
    always_comb begin
        is_div  = bus.op == 3'd3 || bus.op == 3'd4;
        is_sdiv = bus.op == 3'd3;
        dz      = bus.b == 32'd0;
        abs_a   = (is_sdiv && bus.a[31]) ? -bus.a : bus.a;
        abs_b   = (is_sdiv && bus.b[31]) ? -bus.b : bus.b;
        // divide-by-zero result is never committed; 1 keeps the divider defined
        dvs     = dz ? 32'd1 : abs_b;
        q       = abs_a / dvs;
        r       = abs_a % dvs;
        res = bus.op == 3'd1 ? {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b} :
              bus.op == 3'd2 ? {32'd0, bus.a} * {32'd0, bus.b} :
              is_sdiv        ? {(bus.a[31] ? -r : r), ((bus.a[31] ^ bus.b[31]) ? -q : q)} :
                               {r, q};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend    <= 64'd0;
            pend_ok <= 1'b0;
            bus.busy <= 1'b0;
            bus.hi  <= 32'd0;
            bus.lo  <= 32'd0;
        end else if (state == IDLE) begin
            if (bus.start && !bus.flush) begin
                if (bus.op inside {[3'd1:3'd4]}) begin
                    pend     <= res;
                    pend_ok  <= !(is_div && dz);
                    cnt      <= is_div ? 4'(DIV_CYC - 1) : 4'(MULT_CYC - 1);
                    state    <= RUN;
                    bus.busy <= 1'b1;
                end else if (bus.op == 3'd5) begin
                    bus.hi <= bus.a;
                end else if (bus.op == 3'd6) begin
                    bus.lo <= bus.a;
                end
            end
        end else if (bus.flush) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            bus.busy <= 1'b0;
        end else if (cnt == 4'd0) begin
            if (pend_ok) {bus.hi, bus.lo} <= pend;
            state    <= IDLE;
            bus.busy <= 1'b0;
        end else begin
            cnt <= cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: table-driven, hand-sequenced and randomized checks of mdu_iter
// against an arithmetic HI/LO model.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    mdu_if bus ();
    mdu_iter #(.MULT_CYC(5), .DIV_CYC(10)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sq, sr;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = p;
            end
            3'd2: {m_hi, m_lo} = {32'd0, a} * {32'd0, b};
            3'd3: if (b != 0) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000;
                    m_hi = 32'd0;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    m_lo = sq;
                    m_hi = sr;
                end
            end
            3'd4: if (b != 0) begin
                m_lo = a / b;
                m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 50) begin
            cyc++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        issue(op, a, b);
        wait_idle(cyc);
    endtask

    vec_t vecs[9];
    int cyc;

    initial begin
        logic [2:0] rop;
        logic [31:0] ra, rb;
        bus.start = 1'b0;
        bus.op = 3'd0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.flush = 1'b0;
        vecs[0] = '{3'd1, 32'hFFFF_FFFE, 32'd3,          5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  5,  32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,          10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{3'd4, 32'h8000_0000, 32'd3,          10, 32'd2,         32'h2AAA_AAAA};
        vecs[4] = '{3'd5, 32'h0000_1234, 32'd0,          0,  32'h0000_1234, 32'h2AAA_AAAA};
        vecs[5] = '{3'd6, 32'h0000_5678, 32'd0,          0,  32'h0000_1234, 32'h0000_5678};
        vecs[6] = '{3'd3, 32'd99,        32'd0,          10, 32'h0000_1234, 32'h0000_5678};
        vecs[7] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  10, 32'd0,         32'h8000_0000};
        vecs[8] = '{3'd3, 32'd7,         32'hFFFF_FFFE,  10, 32'd1,         32'hFFFF_FFFD};
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy}, 32'd0);
        check("reset_hi", bus.hi, 32'd0);
        check("reset_lo", bus.lo, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            model(vecs[i].op, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_cyc", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
        end
        // start while running is dropped
        issue(3'd3, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        issue(3'd6, 32'h0000_DEAD, 32'd0);
        wait_idle(cyc);
        model(3'd3, 32'd100, 32'd7);
        check("ign_cyc", cyc + 2, 32'd10);
        check("ign_hi", bus.hi, 32'd2);
        check("ign_lo", bus.lo, 32'd14);
        // flush mid-divide discards the result
        issue(3'd3, 32'd1000, 32'd3);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("fl_busy_before", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("fl_busy", {31'd0, bus.busy}, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("fl_hi", bus.hi, m_hi);
        check("fl_lo", bus.lo, m_lo);
        // flush blocks a same-cycle start in IDLE
        bus.flush = 1'b1;
        issue(3'd5, 32'hBEEF_0000, 32'd0);
        issue(3'd1, 32'd3, 32'd3);
        bus.flush = 1'b0;
        check("fs_busy", {31'd0, bus.busy}, 32'd0);
        check("fs_hi", bus.hi, m_hi);
        check("fs_lo", bus.lo, m_lo);
        // async reset mid-mult
        issue(3'd1, 32'd6, 32'd7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_busy", {31'd0, bus.busy}, 32'd0);
        check("ar_hi", bus.hi, 32'd0);
        check("ar_lo", bus.lo, 32'd0);
        #1;
        rst_n = 1'b1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        run_op(3'd1, 32'd6, 32'hFFFF_FFF9, cyc);
        model(3'd1, 32'd6, 32'hFFFF_FFF9);
        check("ar_mult_cyc", cyc, 32'd5);
        check("ar_mult_hi", bus.hi, m_hi);
        check("ar_mult_lo", bus.lo, m_lo);
        // randomized back-to-back traffic
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            run_op(rop, ra, rb, cyc);
            model(rop, ra, rb);
            check($sformatf("rnd%0d_cyc", i), cyc, (rop <= 3'd2) ? 5 : (rop <= 3'd4) ? 10 : 0);
            check($sformatf("rnd%0d_hi", i), bus.hi, m_hi);
            check($sformatf("rnd%0d_lo", i), bus.lo, m_lo);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
